// File: rtl/chebyii_coef_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : chebyii_coef_loader_if
//  Brief    : Write/commit/status bundle for the Chebyshev-II coefficient
//             loader. The master side issues writes and commits; the slave
//             side is the loader itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface chebyii_coef_loader_if;
    logic           wr_valid;
    logic           wr_ready;
    logic [3:0]     wr_addr;
    logic [15:0]    wr_data;
    logic           commit;
    logic           sample_strobe;
    logic           err_clr;
    logic [239:0]   coef_bus;
    logic           pending;
    logic           commit_done;
    logic           err_addr;
    logic           err_incomplete;

    modport master (
        output wr_valid, wr_addr, wr_data, commit, sample_strobe, err_clr,
        input  wr_ready, coef_bus, pending, commit_done, err_addr, err_incomplete
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit, sample_strobe, err_clr,
        output wr_ready, coef_bus, pending, commit_done, err_addr, err_incomplete
    );
endinterface
`default_nettype wire

// File: rtl/chebyii_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module   : chebyii_coef_loader
//  Brief    : Double-buffered coefficient store for a 3-section biquad
//             cascade. Writes land in a shadow bank; a complete commit is
//             applied to the active bank on the next sample boundary so the
//             filter never sees a half-updated set. rst is active-low.
//  Revision : 1.0 - initial release
// ============================================================================
module chebyii_coef_loader #(
    parameter logic signed [15:0] COEF_RESET_B0 = 16'sh4000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    chebyii_coef_loader_if.slave    bus
);

    localparam int         c_NUM_COEF = 15;
    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_ARMED    = 1'b1;

    logic [0:0]            r_state;
    logic [15:0]           r_shadow [0:c_NUM_COEF-1];
    logic [15:0]           r_active [0:c_NUM_COEF-1];
    logic [c_NUM_COEF-1:0] r_mask;
    logic                  r_commit_done;
    logic                  r_err_addr;
    logic                  r_err_incomplete;

    logic                  w_idle;
    logic                  w_wr_fire;
    logic                  w_wr_store;
    logic [c_NUM_COEF-1:0] w_wr_bit;
    logic                  w_mask_full;
    logic                  w_commit_ok;
    logic                  w_commit_bad;
    logic                  w_apply;

    // Write/commit qualification; a write in the commit cycle counts toward completeness
    always_comb begin
        w_idle       = (r_state == c_IDLE);
        w_wr_fire    = bus.wr_valid && w_idle;
        w_wr_store   = w_wr_fire && (bus.wr_addr != 4'd15);
        w_wr_bit     = w_wr_store ? (c_NUM_COEF'(1) << bus.wr_addr) : '0;
        w_mask_full  = &(r_mask | w_wr_bit);
        w_commit_ok  = w_idle && bus.commit && w_mask_full;
        w_commit_bad = w_idle && bus.commit && !w_mask_full;
        w_apply      = (r_state == c_ARMED) && bus.sample_strobe;
    end

    // Commit FSM, written mask and the one-cycle commit_done pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_IDLE;
            r_mask        <= '0;
            r_commit_done <= 1'b0;
        end else begin
            r_commit_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_mask <= r_mask | w_wr_bit;
                    if (w_commit_ok) begin
                        r_state <= c_ARMED;
                    end
                end
                c_ARMED: begin
                    if (w_apply) begin
                        r_mask        <= '0;
                        r_commit_done <= 1'b1;
                        r_state       <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Shadow bank: accepted in-range writes only; contents survive a commit
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < c_NUM_COEF; i++) begin
                r_shadow[i] <= (i % 5 == 0) ? COEF_RESET_B0 : 16'h0000;
            end
        end else if (w_wr_store) begin
            r_shadow[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Active bank: whole-bank copy on the sample boundary after a commit
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < c_NUM_COEF; i++) begin
                r_active[i] <= (i % 5 == 0) ? COEF_RESET_B0 : 16'h0000;
            end
        end else if (w_apply) begin
            for (int i = 0; i < c_NUM_COEF; i++) begin
                r_active[i] <= r_shadow[i];
            end
        end
    end

    // Sticky error flags; a setting event in the same cycle beats err_clr
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_addr       <= 1'b0;
            r_err_incomplete <= 1'b0;
        end else begin
            if (w_wr_fire && (bus.wr_addr == 4'd15)) begin
                r_err_addr <= 1'b1;
            end else if (bus.err_clr) begin
                r_err_addr <= 1'b0;
            end
            if (w_commit_bad) begin
                r_err_incomplete <= 1'b1;
            end else if (bus.err_clr) begin
                r_err_incomplete <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < c_NUM_COEF; gi++) begin : g_bus
            assign bus.coef_bus[16*gi +: 16] = r_active[gi];
        end
    endgenerate

    assign bus.wr_ready       = (r_state == c_IDLE);
    assign bus.pending        = (r_state == c_ARMED);
    assign bus.commit_done    = r_commit_done;
    assign bus.err_addr       = r_err_addr;
    assign bus.err_incomplete = r_err_incomplete;

endmodule
`default_nettype wire

// File: tb/tb_chebyii_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chebyii_coef_loader
//  Brief    : Directed self-checking bench for chebyii_coef_loader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_chebyii_coef_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    chebyii_coef_loader_if bus_if ();

    chebyii_coef_loader #(.COEF_RESET_B0(16'sh4000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [239:0] reset_bus();
        logic [239:0] b;
        b = '0;
        b[0   +: 16] = 16'h4000;
        b[80  +: 16] = 16'h4000;
        b[160 +: 16] = 16'h4000;
        return b;
    endfunction

    function automatic logic [239:0] ramp_bus(input logic [15:0] base);
        logic [239:0] b;
        b = '0;
        for (int i = 0; i < 15; i++) b[16*i +: 16] = base + 16'(i);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr  = a;
        bus_if.wr_data  = d;
        tick();
        bus_if.wr_valid = 1'b0;
    endtask

    task automatic write_ramp(input int lo, input int hi, input logic [15:0] base);
        for (int i = lo; i <= hi; i++) write_word(4'(i), base + 16'(i));
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus_if.pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got=%b exp=0", bus_if.pending); end
        n_cmp++; if (bus_if.commit_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus_if.commit_done); end
        n_cmp++; if (bus_if.err_addr !== 1'b0) begin n_bad++; $display("FAIL reset_err_addr got=%b exp=0", bus_if.err_addr); end
        n_cmp++; if (bus_if.err_incomplete !== 1'b0) begin n_bad++; $display("FAIL reset_err_inc got=%b exp=0", bus_if.err_incomplete); end
        n_cmp++; if (bus_if.wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready got=%b exp=1", bus_if.wr_ready); end
        n_cmp++; if (bus_if.coef_bus !== reset_bus()) begin n_bad++; $display("FAIL reset_bus got=%h exp=%h", bus_if.coef_bus, reset_bus()); end
    endtask

    task automatic test_full_load();
        do_reset();
        write_ramp(0, 14, 16'h1000);
        bus_if.commit = 1'b1;
        tick();
        bus_if.commit = 1'b0;
        n_cmp++; if (bus_if.pending !== 1'b1) begin n_bad++; $display("FAIL full_pending0 got=%b exp=1", bus_if.pending); end
        n_cmp++; if (bus_if.wr_ready !== 1'b0) begin n_bad++; $display("FAIL full_wr_ready got=%b exp=0", bus_if.wr_ready); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_cmp++; if (bus_if.pending !== 1'b1) begin n_bad++; $display("FAIL full_pending%0d got=%b exp=1", c, bus_if.pending); end
            n_cmp++; if (bus_if.coef_bus !== reset_bus()) begin n_bad++; $display("FAIL full_bus_hold%0d got=%h exp=%h", c, bus_if.coef_bus, reset_bus()); end
            n_cmp++; if (bus_if.commit_done !== 1'b0) begin n_bad++; $display("FAIL full_done_early%0d got=%b exp=0", c, bus_if.commit_done); end
        end
        bus_if.sample_strobe = 1'b1;
        tick();
        bus_if.sample_strobe = 1'b0;
        n_cmp++; if (bus_if.coef_bus !== ramp_bus(16'h1000)) begin n_bad++; $display("FAIL full_bus got=%h exp=%h", bus_if.coef_bus, ramp_bus(16'h1000)); end
        n_cmp++; if (bus_if.commit_done !== 1'b1) begin n_bad++; $display("FAIL full_done got=%b exp=1", bus_if.commit_done); end
        n_cmp++; if (bus_if.pending !== 1'b0) begin n_bad++; $display("FAIL full_pending_after got=%b exp=0", bus_if.pending); end
        tick();
        n_cmp++; if (bus_if.commit_done !== 1'b0) begin n_bad++; $display("FAIL full_done_pulse got=%b exp=0", bus_if.commit_done); end
        n_cmp++; if (bus_if.coef_bus !== ramp_bus(16'h1000)) begin n_bad++; $display("FAIL full_bus_keep got=%h exp=%h", bus_if.coef_bus, ramp_bus(16'h1000)); end
        // mask was cleared by the apply, so an immediate recommit is incomplete
        bus_if.commit = 1'b1;
        tick();
        bus_if.commit = 1'b0;
        n_cmp++; if (bus_if.err_incomplete !== 1'b1) begin n_bad++; $display("FAIL full_recommit_err got=%b exp=1", bus_if.err_incomplete); end
        n_cmp++; if (bus_if.pending !== 1'b0) begin n_bad++; $display("FAIL full_recommit_pending got=%b exp=0", bus_if.pending); end
    endtask

    task automatic test_incomplete();
        do_reset();
        write_ramp(0, 13, 16'h1000);
        bus_if.commit = 1'b1;
        tick();
        n_cmp++; if (bus_if.err_incomplete !== 1'b1) begin n_bad++; $display("FAIL inc_err got=%b exp=1", bus_if.err_incomplete); end
        n_cmp++; if (bus_if.pending !== 1'b0) begin n_bad++; $display("FAIL inc_pending got=%b exp=0", bus_if.pending); end
        n_cmp++; if (bus_if.coef_bus !== reset_bus()) begin n_bad++; $display("FAIL inc_bus got=%h exp=%h", bus_if.coef_bus, reset_bus()); end
        // clear collides with a new incomplete commit: the set wins
        bus_if.err_clr = 1'b1;
        tick();
        bus_if.commit = 1'b0;
        n_cmp++; if (bus_if.err_incomplete !== 1'b1) begin n_bad++; $display("FAIL inc_set_wins got=%b exp=1", bus_if.err_incomplete); end
        tick();
        bus_if.err_clr = 1'b0;
        n_cmp++; if (bus_if.err_incomplete !== 1'b0) begin n_bad++; $display("FAIL inc_clr got=%b exp=0", bus_if.err_incomplete); end
        n_cmp++; if (bus_if.err_addr !== 1'b0) begin n_bad++; $display("FAIL inc_err_addr got=%b exp=0", bus_if.err_addr); end
    endtask

    task automatic test_write_and_commit();
        do_reset();
        write_ramp(0, 13, 16'h3000);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr  = 4'd14;
        bus_if.wr_data  = 16'h300E;
        bus_if.commit   = 1'b1;
        tick();
        bus_if.wr_valid = 1'b0;
        bus_if.commit   = 1'b0;
        n_cmp++; if (bus_if.pending !== 1'b1) begin n_bad++; $display("FAIL wc_pending got=%b exp=1", bus_if.pending); end
        n_cmp++; if (bus_if.err_incomplete !== 1'b0) begin n_bad++; $display("FAIL wc_err got=%b exp=0", bus_if.err_incomplete); end
        bus_if.sample_strobe = 1'b1;
        tick();
        bus_if.sample_strobe = 1'b0;
        n_cmp++; if (bus_if.coef_bus !== ramp_bus(16'h3000)) begin n_bad++; $display("FAIL wc_bus got=%h exp=%h", bus_if.coef_bus, ramp_bus(16'h3000)); end
        n_cmp++; if (bus_if.commit_done !== 1'b1) begin n_bad++; $display("FAIL wc_done got=%b exp=1", bus_if.commit_done); end
    endtask

    task automatic test_bad_addr();
        do_reset();
        write_ramp(0, 13, 16'h5000);
        write_word(4'd15, 16'hBEEF);
        n_cmp++; if (bus_if.err_addr !== 1'b1) begin n_bad++; $display("FAIL bad_err_addr got=%b exp=1", bus_if.err_addr); end
        bus_if.commit = 1'b1;
        tick();
        bus_if.commit = 1'b0;
        n_cmp++; if (bus_if.err_incomplete !== 1'b1) begin n_bad++; $display("FAIL bad_mask_err got=%b exp=1", bus_if.err_incomplete); end
        n_cmp++; if (bus_if.pending !== 1'b0) begin n_bad++; $display("FAIL bad_mask_pending got=%b exp=0", bus_if.pending); end
        write_word(4'd14, 16'h500E);
        bus_if.commit = 1'b1;
        tick();
        bus_if.commit = 1'b0;
        n_cmp++; if (bus_if.pending !== 1'b1) begin n_bad++; $display("FAIL bad_pending got=%b exp=1", bus_if.pending); end
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr  = 4'd0;
        bus_if.wr_data  = 16'hDEAD;
        #1;
        n_cmp++; if (bus_if.wr_ready !== 1'b0) begin n_bad++; $display("FAIL bad_armed_ready got=%b exp=0", bus_if.wr_ready); end
        tick();
        bus_if.wr_valid      = 1'b0;
        bus_if.sample_strobe = 1'b1;
        tick();
        bus_if.sample_strobe = 1'b0;
        n_cmp++; if (bus_if.coef_bus !== ramp_bus(16'h5000)) begin n_bad++; $display("FAIL bad_bus got=%h exp=%h", bus_if.coef_bus, ramp_bus(16'h5000)); end
        n_cmp++; if (bus_if.err_addr !== 1'b1) begin n_bad++; $display("FAIL bad_sticky got=%b exp=1", bus_if.err_addr); end
        bus_if.err_clr = 1'b1;
        tick();
        bus_if.err_clr = 1'b0;
        n_cmp++; if (bus_if.err_addr !== 1'b0) begin n_bad++; $display("FAIL bad_clr got=%b exp=0", bus_if.err_addr); end
    endtask

    task automatic test_strobe_same_cycle();
        do_reset();
        write_ramp(0, 14, 16'h2000);
        bus_if.commit        = 1'b1;
        bus_if.sample_strobe = 1'b1;
        tick();
        bus_if.sample_strobe = 1'b0;
        n_cmp++; if (bus_if.pending !== 1'b1) begin n_bad++; $display("FAIL same_pending got=%b exp=1", bus_if.pending); end
        n_cmp++; if (bus_if.commit_done !== 1'b0) begin n_bad++; $display("FAIL same_done got=%b exp=0", bus_if.commit_done); end
        n_cmp++; if (bus_if.coef_bus !== reset_bus()) begin n_bad++; $display("FAIL same_bus got=%h exp=%h", bus_if.coef_bus, reset_bus()); end
        // commit held high while armed must be ignored without error
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_cmp++; if (bus_if.coef_bus !== reset_bus()) begin n_bad++; $display("FAIL same_hold%0d got=%h exp=%h", c, bus_if.coef_bus, reset_bus()); end
            n_cmp++; if (bus_if.err_incomplete !== 1'b0) begin n_bad++; $display("FAIL same_armed_commit%0d got=%b exp=0", c, bus_if.err_incomplete); end
        end
        bus_if.commit        = 1'b0;
        bus_if.sample_strobe = 1'b1;
        tick();
        bus_if.sample_strobe = 1'b0;
        n_cmp++; if (bus_if.coef_bus !== ramp_bus(16'h2000)) begin n_bad++; $display("FAIL same_bus_apply got=%h exp=%h", bus_if.coef_bus, ramp_bus(16'h2000)); end
        n_cmp++; if (bus_if.commit_done !== 1'b1) begin n_bad++; $display("FAIL same_done_apply got=%b exp=1", bus_if.commit_done); end
    endtask

    task automatic test_reset_armed();
        do_reset();
        write_ramp(0, 14, 16'h6000);
        bus_if.commit = 1'b1;
        tick();
        bus_if.commit        = 1'b0;
        bus_if.sample_strobe = 1'b1;
        tick();
        bus_if.sample_strobe = 1'b0;
        n_cmp++; if (bus_if.coef_bus !== ramp_bus(16'h6000)) begin n_bad++; $display("FAIL rarm_pre_bus got=%h exp=%h", bus_if.coef_bus, ramp_bus(16'h6000)); end
        write_ramp(0, 14, 16'h7000);
        bus_if.commit = 1'b1;
        tick();
        bus_if.commit = 1'b0;
        n_cmp++; if (bus_if.pending !== 1'b1) begin n_bad++; $display("FAIL rarm_pending got=%b exp=1", bus_if.pending); end
        // reset together with a strobe: reset wins
        rst                  = 1'b0;
        bus_if.sample_strobe = 1'b1;
        tick();
        rst                  = 1'b1;
        bus_if.sample_strobe = 1'b0;
        n_cmp++; if (bus_if.pending !== 1'b0) begin n_bad++; $display("FAIL rarm_pending_after got=%b exp=0", bus_if.pending); end
        n_cmp++; if (bus_if.commit_done !== 1'b0) begin n_bad++; $display("FAIL rarm_done got=%b exp=0", bus_if.commit_done); end
        n_cmp++; if (bus_if.coef_bus !== reset_bus()) begin n_bad++; $display("FAIL rarm_bus got=%h exp=%h", bus_if.coef_bus, reset_bus()); end
    endtask

    initial begin
        bus_if.wr_valid      = 1'b0;
        bus_if.wr_addr       = 4'd0;
        bus_if.wr_data       = 16'h0000;
        bus_if.commit        = 1'b0;
        bus_if.sample_strobe = 1'b0;
        bus_if.err_clr       = 1'b0;
        #2;
        test_reset();
        test_full_load();
        test_incomplete();
        test_write_and_commit();
        test_bad_addr();
        test_strobe_same_cycle();
        test_reset_armed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chebyii_coef_loader.md
CHEBYII_COEF_LOADER -- requirements
Module: chebyii_coef_loader

Interface
- REQ-001 Parameter: COEF_RESET_B0, 16'sh4000, reset value of every b_0 coefficient (1.0 in Q2.14).
- REQ-002 CLK  in  1  sole clock; all logic on rising edge.
- REQ-003 RST  in  1  reset, synchronous, active-low.
- REQ-004 wr_valid  in  1  coefficient write request.
- REQ-005 wr_ready  out  1  write accepted when wr_valid && wr_ready.
- REQ-006 wr_addr  in  4  coefficient index 0..14.
- REQ-007 wr_data  in  16  signed coefficient value.
- REQ-008 commit  in  1  request to apply the shadow bank.
- REQ-009 sample_strobe  in  1  one-cycle pulse marking a filter sample boundary.
- REQ-010 err_clr  in  1  clears sticky error flags.
- REQ-011 coef_bus  out  240  active coefficients; index i occupies bits [16*i+15:16*i].
- REQ-012 Index map: i = 5*k + j; k = section 0..2; j = 0:b_0, 1:b_1, 2:b_2, 3:a_1, 4:a_2.
- REQ-013 pending  out  1  commit armed, waiting for sample_strobe.
- REQ-014 commit_done  out  1  one-cycle pulse when the active bank is updated.
- REQ-015 err_addr  out  1  sticky; a write to index 15 occurred.
- REQ-016 err_incomplete  out  1  sticky; commit requested before all 15 entries were written.

Function
- REQ-017 Storage: 15x16 shadow bank, 15x16 active bank, 15-bit written mask.
- REQ-018 States: IDLE (pending=0), ARMED (pending=1).
- REQ-019 wr_ready = !pending (combinational from state only).
- REQ-020 Accepted write, addr 0..14: shadow[addr] <= wr_data and mask[addr] <= 1 at the same edge.
- REQ-021 Accepted write, addr 15: shadow and mask unchanged; err_addr <= 1.
- REQ-022 IDLE, commit=1, (mask | bit written this cycle) == all-ones: go to ARMED next cycle.
- REQ-023 Simultaneous write and commit: the write lands first, and its bit counts toward completeness.
- REQ-024 IDLE, commit=1, mask incomplete: stay in IDLE; err_incomplete <= 1; shadow untouched.
- REQ-025 ARMED, sample_strobe=1: active <= shadow; mask <= 0; commit_done=1 for exactly that next cycle; return to IDLE.
- REQ-026 A sample_strobe in the same cycle that commit is accepted does not apply; the next strobe applies.
- REQ-027 commit while ARMED: ignored, with no error.
- REQ-028 coef_bus changes only at the edge defined in REQ-025; it is never partially updated.
- REQ-029 Latency: commit accepted at edge N gives pending=1 after N. Strobe sampled at edge M>N gives coef_bus new and commit_done=1 after M.
- REQ-030 err_clr=1: both error flags <= 0. A simultaneous error-setting event wins, and the flag stays 1.
- REQ-031 Shadow retains its contents after a commit. Only the mask clears, so a full rewrite is required before the next commit.

Reset
- REQ-032 With RST=0 at an edge: state IDLE, pending=0, commit_done=0, err_addr=0, err_incomplete=0, mask=0.
- REQ-033 Same reset edge: active and shadow b_0 entries (i=0,5,10) = COEF_RESET_B0; all other entries = 0.
- REQ-034 Reset in ARMED abandons the pending commit; coef_bus returns to reset values.
- REQ-035 Reset has priority over every other input in the same cycle.

Verification
- REQ-036 Write 0x1000+i to i=0..14, commit, then strobe 3 cycles later. Response: pending=1 for 4 cycles, then coef_bus[16i+:16]=0x1000+i; commit_done pulses once.
- REQ-037 Write i=0..13 only, then commit. Response: err_incomplete=1, pending=0, coef_bus still reset values; err_clr then clears the flag.
- REQ-038 Write i=0..13, then write i=14 and commit in the same cycle. Response: ARMED next cycle; no error.
- REQ-039 Write to addr 15 with data 0xBEEF. Response: err_addr=1; mask and shadow unchanged; a write with wr_valid=1 during ARMED sees wr_ready=0.
- REQ-040 Commit and strobe in the same cycle. Response: no update. A second strobe 5 cycles later applies; coef_bus is constant before it.
- REQ-041 Assert RST=0 while ARMED. Response: next cycle pending=0; coef_bus holds 0x4000 at i=0,5,10 and 0 elsewhere.
